// File: rtl/voxel_fb_pkg.sv
// Shared definitions for the raycaster pixel-write path and the host framebuffer model.
package voxel_fb_pkg;

    // Payload carried per pixel: three 32-bit words.
    localparam int PIX_DATA_W     = 96;
    // Default frame geometry (320x240) and the pixel index width it needs.
    localparam int DEF_NUM_PIXELS = 76800;
    localparam int DEF_IDX_W      = 17;

    // One FIFO slot. A slot with has_pix = 0 only carries an end-of-frame marker.
    typedef struct packed {
        logic                   has_pix;
        logic                   eof;
        logic [DEF_IDX_W-1:0]   idx;
        logic [PIX_DATA_W-1:0]  data;
    } pix_entry_t;

    localparam int ENTRY_W = $bits(pix_entry_t);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/voxel_pixel_sink_if.sv
// Bundle of the pixel-write input stream, the framebuffer write port and status.
interface voxel_pixel_sink_if
    import voxel_fb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = DEF_IDX_W
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    // Raycaster side
    logic                   pixel_write_en;
    logic [31:0]            pixel_addr;
    logic [31:0]            pixel_word0;
    logic [31:0]            pixel_word1;
    logic [31:0]            pixel_word2;
    logic                   frame_done;

    // Framebuffer memory side
    logic                   mem_wvalid;
    logic                   mem_wready;
    logic [IDX_W:0]         mem_waddr;
    logic [PIX_DATA_W-1:0]  mem_wdata;

    // Status
    logic                   frame_complete;
    logic                   buf_sel;
    logic [LVL_W-1:0]       fifo_level;
    logic [15:0]            overflow_count;
    logic [15:0]            range_err_count;

    // Environment view: produces pixels, plays the memory, observes status.
    modport master (
        output pixel_write_en, pixel_addr, pixel_word0, pixel_word1, pixel_word2,
        output frame_done, mem_wready,
        input  mem_wvalid, mem_waddr, mem_wdata,
        input  frame_complete, buf_sel, fifo_level, overflow_count, range_err_count
    );

    // Sink view.
    modport slave (
        input  pixel_write_en, pixel_addr, pixel_word0, pixel_word1, pixel_word2,
        input  frame_done, mem_wready,
        output mem_wvalid, mem_waddr, mem_wdata,
        output frame_complete, buf_sel, fifo_level, overflow_count, range_err_count
    );

endinterface

// File: rtl/voxel_pixel_sink_fifo.sv
// Synchronous FIFO with a registered head word and registered full/empty/level.
// The head register is refreshed on the same edge a push lands in an empty
// FIFO, so a written entry is visible at the output right after that edge.
module voxel_pixel_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [LVL_W-1:0] o_level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_head;
    logic             r_empty;
    logic             r_full;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [PTR_W-1:0] w_rd_ptr_p1;
    logic [LVL_W-1:0] w_level_next;

    // Full is judged before this cycle's pop: no pass-through when full.
    assign w_push_ok   = i_push && !r_full;
    assign w_pop_ok    = i_pop && !r_empty;
    assign w_rd_ptr_p1 = r_rd_ptr + PTR_W'(1);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_level_next = r_level
                     + {{(LVL_W-1){1'b0}}, w_push_ok}
                     - {{(LVL_W-1){1'b0}}, w_pop_ok};
    end

    // Storage write; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and flags; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_ptr_p1;
            end
            r_level <= w_level_next;
            r_empty <= (w_level_next == '0);
            r_full  <= (w_level_next == LVL_W'(DEPTH));
        end
    end

    // Head register: next stored entry on pop, or the incoming word when the
    // entry behind the head (or the head itself) is being written this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
        end else if (w_pop_ok) begin
            if (r_level >= LVL_W'(2)) begin
                r_head <= r_mem[w_rd_ptr_p1];
            end else if (w_push_ok) begin
                r_head <= i_wdata;
            end
        end else if (r_empty && w_push_ok) begin
            r_head <= i_wdata;
        end
    end

    assign o_head  = r_head;
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_level = r_level;

endmodule

// File: rtl/voxel_pixel_sink.sv
// Receiving end of the raycaster pixel-write stream: classifies incoming
// pixels, queues them with end-of-frame markers and drains them to a
// double-buffered framebuffer write port.
module voxel_pixel_sink
    import voxel_fb_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int IDX_W      = DEF_IDX_W   // must not exceed DEF_IDX_W (entry idx field)
) (
    input logic                clk,
    input logic                rst_n,
    voxel_pixel_sink_if.slave  bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             r_eof_pending;
    logic             r_buf_sel;
    logic             r_frame_complete;
    logic [15:0]      r_overflow_count;
    logic [15:0]      r_range_err_count;

    logic             w_in_range;
    logic             w_pix_ok;
    logic             w_range_err;
    logic             w_eof_in;
    logic             w_push_req;
    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level;
    logic [ENTRY_W-1:0] w_head_bits;
    pix_entry_t       w_head;
    pix_entry_t       w_entry;
    logic             w_pop;
    logic             w_eof_pop;

    // Per-cycle input classification. A held-back marker rides along with the
    // next pushed entry, or goes alone as soon as there is room.
    assign w_in_range  = (bus.pixel_addr < 32'(NUM_PIXELS));
    assign w_pix_ok    = bus.pixel_write_en && w_in_range;
    assign w_range_err = bus.pixel_write_en && !w_in_range;
    assign w_eof_in    = bus.frame_done || r_eof_pending;
    assign w_push_req  = w_pix_ok || w_eof_in;

    // Build the entry; marker-only entries carry zero index and data.
    always_comb begin
        w_entry         = '0;
        w_entry.has_pix = w_pix_ok;
        w_entry.eof     = w_eof_in;
        if (w_pix_ok) begin
            w_entry.idx  = DEF_IDX_W'(bus.pixel_addr[IDX_W-1:0]);
            w_entry.data = {bus.pixel_word2, bus.pixel_word1, bus.pixel_word0};
        end
    end

    voxel_pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_req),
        .i_wdata (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head_bits),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (w_level)
    );

    assign w_head = pix_entry_t'(w_head_bits);

    // Pixel entries wait for the memory; marker-only entries leave immediately.
    assign w_pop     = !w_empty && (!w_head.has_pix || bus.mem_wready);
    assign w_eof_pop = w_pop && w_head.eof;

    // Frame bookkeeping: completion pulse and buffer flip on the edge that
    // retires the entry carrying end-of-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_complete <= 1'b0;
            r_buf_sel        <= 1'b0;
        end else begin
            r_frame_complete <= w_eof_pop;
            if (w_eof_pop) begin
                r_buf_sel <= ~r_buf_sel;
            end
        end
    end

    // Marker hold-back: set while the FIFO is too full to take it, cleared on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eof_pending <= 1'b0;
        end else if (w_eof_in) begin
            r_eof_pending <= w_full;
        end
    end

    // Saturating drop counters for full-FIFO and out-of-range pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow_count  <= '0;
            r_range_err_count <= '0;
        end else begin
            if (w_pix_ok && w_full) begin
                r_overflow_count <= sat_inc16(r_overflow_count);
            end
            if (w_range_err) begin
                r_range_err_count <= sat_inc16(r_range_err_count);
            end
        end
    end

    assign bus.mem_wvalid      = !w_empty && w_head.has_pix;
    assign bus.mem_waddr       = {r_buf_sel, w_head.idx[IDX_W-1:0]};
    assign bus.mem_wdata       = w_head.data;
    assign bus.frame_complete  = r_frame_complete;
    assign bus.buf_sel         = r_buf_sel;
    assign bus.fifo_level      = w_level;
    assign bus.overflow_count  = r_overflow_count;
    assign bus.range_err_count = r_range_err_count;

endmodule

// File: tb/tb_voxel_pixel_sink.sv
// Self-checking bench for voxel_pixel_sink: scoreboard of expected memory
// writes/markers plus a table of range-classification vectors.
module tb_voxel_pixel_sink;
    import voxel_fb_pkg::*;

    localparam int DEPTH = 16;
    localparam int IDX_W = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    voxel_pixel_sink_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) vif ();

    voxel_pixel_sink #(
        .DEPTH      (DEPTH),
        .NUM_PIXELS (76800),
        .IDX_W      (IDX_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    typedef struct {
        logic           has_pix;
        logic           eof;
        logic [IDX_W:0] addr;
        logic [95:0]    data;
    } sb_t;

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic        acc;
        logic [15:0] exp_rerr;
    } vec_t;

    sb_t         sb_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          fc_total = 0;
    logic        m_buf = 1'b0;
    logic        mon_buf = 1'b0;
    logic        exp_fc = 1'b0;
    logic        prev_stall = 1'b0;
    logic [IDX_W:0] prev_addr = '0;
    logic [95:0] prev_data = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] mk_data(input int i);
        return {32'hC000_0000 | 32'(i), 32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
    endfunction

    task automatic expect_pix(input int idx, input logic [95:0] d, input logic eof);
        sb_t r;
        r.has_pix = 1'b1;
        r.eof     = eof;
        r.addr    = {m_buf, IDX_W'(idx)};
        r.data    = d;
        sb_q.push_back(r);
        if (eof) m_buf = ~m_buf;
    endtask

    task automatic expect_marker();
        sb_t r;
        r.has_pix = 1'b0;
        r.eof     = 1'b1;
        r.addr    = '0;
        r.data    = '0;
        sb_q.push_back(r);
        m_buf = ~m_buf;
    endtask

    task automatic drive(input logic en, input logic [31:0] addr, input logic [95:0] d, input logic fd);
        vif.pixel_write_en = en;
        vif.pixel_addr     = addr;
        {vif.pixel_word2, vif.pixel_word1, vif.pixel_word0} = d;
        vif.frame_done     = fd;
        @(posedge clk); #1;
        vif.pixel_write_en = 1'b0;
        vif.frame_done     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drained(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sb_q.size() == 0 && vif.fifo_level == '0) break;
            @(posedge clk); #1;
        end
        check("drain_pending", 128'(sb_q.size()), 128'(0));
    endtask

    // Monitor: compares every handshake/marker pop against the scoreboard,
    // checks frame_complete/buf_sel timing and stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_buf    = 1'b0;
            exp_fc     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            sb_t r;
            check("frame_complete", 128'(vif.frame_complete), 128'(exp_fc));
            check("buf_sel", 128'(vif.buf_sel), 128'(mon_buf));
            if (vif.frame_complete) fc_total++;
            if (prev_stall) begin
                check("stall_wvalid", 128'(vif.mem_wvalid), 128'(1'b1));
                check("stall_waddr", 128'(vif.mem_waddr), 128'(prev_addr));
                check("stall_wdata", 128'(vif.mem_wdata), 128'(prev_data));
            end
            exp_fc = 1'b0;
            if (vif.mem_wvalid && vif.mem_wready) begin
                $display("write addr=%05h data=%024h", vif.mem_waddr, vif.mem_wdata);
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 128'(vif.mem_waddr), 128'(0));
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_write: got write addr 0x%0h required none", vif.mem_waddr);
                end else begin
                    r = sb_q.pop_front();
                    check("entry_kind", 128'(1'b1), 128'(r.has_pix));
                    check("mem_waddr", 128'(vif.mem_waddr), 128'(r.addr));
                    check("mem_wdata", 128'(vif.mem_wdata), 128'(r.data));
                    if (r.eof) begin exp_fc = 1'b1; mon_buf = ~mon_buf; end
                end
            end else if (!vif.mem_wvalid && vif.fifo_level != '0) begin
                $display("marker pop level=%0d", vif.fifo_level);
                if (sb_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_marker: got marker pop required none");
                end else begin
                    r = sb_q.pop_front();
                    check("marker_kind", 128'(1'b0), 128'(r.has_pix));
                    if (r.eof) begin exp_fc = 1'b1; mon_buf = ~mon_buf; end
                end
            end
            prev_stall = vif.mem_wvalid && !vif.mem_wready;
            prev_addr  = vif.mem_waddr;
            prev_data  = vif.mem_wdata;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[6];
        int   sent;
        int   fc_before;

        vt[0] = '{1'b1, 32'd76800,      1'b0, 16'd1};
        vt[1] = '{1'b1, 32'hFFFF_FFFF,  1'b0, 16'd2};
        vt[2] = '{1'b1, 32'd76799,      1'b1, 16'd2};
        vt[3] = '{1'b0, 32'd12,         1'b0, 16'd2};
        vt[4] = '{1'b1, 32'd0,          1'b1, 16'd2};
        vt[5] = '{1'b1, 32'd76801,      1'b0, 16'd3};

        vif.pixel_write_en = 1'b0;
        vif.pixel_addr     = '0;
        vif.pixel_word0    = '0;
        vif.pixel_word1    = '0;
        vif.pixel_word2    = '0;
        vif.frame_done     = 1'b0;
        vif.mem_wready     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wvalid", 128'(vif.mem_wvalid), 128'(0));
        check("rst_waddr", 128'(vif.mem_waddr), 128'(0));
        check("rst_wdata", 128'(vif.mem_wdata), 128'(0));
        check("rst_fc", 128'(vif.frame_complete), 128'(0));
        check("rst_buf_sel", 128'(vif.buf_sel), 128'(0));
        check("rst_level", 128'(vif.fifo_level), 128'(0));
        check("rst_overflow", 128'(vif.overflow_count), 128'(0));
        check("rst_range_err", 128'(vif.range_err_count), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic drain: three pixels, frame_done with the last
        vif.mem_wready = 1'b1;
        expect_pix(0, 96'h0000000C_0000000B_0000000A, 1'b0);
        drive(1'b1, 32'd0, 96'h0000000C_0000000B_0000000A, 1'b0);
        expect_pix(1, 96'h0000001C_0000001B_0000001A, 1'b0);
        drive(1'b1, 32'd1, 96'h0000001C_0000001B_0000001A, 1'b0);
        expect_pix(2, 96'h0000002C_0000002B_0000002A, 1'b1);
        drive(1'b1, 32'd2, 96'h0000002C_0000002B_0000002A, 1'b1);
        wait_drained(20);
        idle(3);
        check("basic_buf_sel", 128'(vif.buf_sel), 128'(1));
        check("basic_fc_total", 128'(fc_total), 128'(1));
        expect_pix(5, mk_data(5), 1'b0);
        drive(1'b1, 32'd5, mk_data(5), 1'b0);
        @(negedge clk);
        check("latency_wvalid", 128'(vif.mem_wvalid), 128'(1));
        check("next_frame_addr", 128'(vif.mem_waddr), 128'(18'h20005));
        @(posedge clk); #1;
        wait_drained(20);

        // Range classification table
        for (int i = 0; i < 6; i++) begin
            if (vt[i].acc) expect_pix(int'(vt[i].addr[16:0]), mk_data(100 + i), 1'b0);
            drive(vt[i].en, vt[i].addr, mk_data(100 + i), 1'b0);
            @(negedge clk);
            check("range_err_count", 128'(vif.range_err_count), 128'(vt[i].exp_rerr));
            @(posedge clk); #1;
        end
        wait_drained(20);
        check("range_overflow", 128'(vif.overflow_count), 128'(0));

        // Marker-only frame: frame_complete two cycles after the pulse
        idle(2);
        expect_marker();
        vif.frame_done = 1'b1;
        @(posedge clk); #1;
        vif.frame_done = 1'b0;
        @(negedge clk);
        check("marker_fc_early", 128'(vif.frame_complete), 128'(0));
        check("marker_wvalid", 128'(vif.mem_wvalid), 128'(0));
        @(negedge clk);
        check("marker_fc", 128'(vif.frame_complete), 128'(1));
        check("marker_wvalid2", 128'(vif.mem_wvalid), 128'(0));
        idle(2);
        check("marker_buf_sel", 128'(vif.buf_sel), 128'(0));

        // Backpressure: fill, overflow, marker held back
        vif.mem_wready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expect_pix(200 + i, mk_data(200 + i), 1'b0);
            drive(1'b1, 32'(200 + i), mk_data(200 + i), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(300 + i), mk_data(300 + i), (i == 2));
        end
        expect_marker();
        @(negedge clk);
        check("bp_level", 128'(vif.fifo_level), 128'(16));
        check("bp_overflow", 128'(vif.overflow_count), 128'(3));
        check("bp_eof_pending", 128'(dut.r_eof_pending), 128'(1));
        idle(4);
        check("bp_level_hold", 128'(vif.fifo_level), 128'(16));
        vif.mem_wready = 1'b1;
        wait_drained(60);
        idle(3);
        check("bp_fc_total", 128'(fc_total), 128'(3));
        check("bp_buf_sel", 128'(vif.buf_sel), 128'(1));
        check("bp_eof_pending_clr", 128'(dut.r_eof_pending), 128'(0));

        // Random stall: 1000 pixels, paced by fifo level
        sent = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (sent == 1000 && sb_q.size() == 0 && vif.fifo_level == '0) break;
            vif.mem_wready = 1'($urandom_range(0, 1));
            if (sent < 1000 && vif.fifo_level < 8) begin
                logic [95:0] d;
                d = {$urandom, $urandom, $urandom};
                expect_pix(sent, d, (sent == 999));
                vif.pixel_write_en = 1'b1;
                vif.pixel_addr     = 32'(sent);
                {vif.pixel_word2, vif.pixel_word1, vif.pixel_word0} = d;
                vif.frame_done     = (sent == 999);
                sent++;
            end
            @(posedge clk); #1;
            vif.pixel_write_en = 1'b0;
            vif.frame_done     = 1'b0;
        end
        vif.mem_wready = 1'b1;
        check("stall_sent", 128'(sent), 128'(1000));
        wait_drained(40);
        idle(3);
        check("stall_overflow", 128'(vif.overflow_count), 128'(3));

        // Reset mid-frame with full FIFO and pending marker
        expect_marker();
        drive(1'b0, 32'd0, '0, 1'b1);
        idle(4);
        check("pre_rst_buf_sel", 128'(vif.buf_sel), 128'(1));
        vif.mem_wready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expect_pix(400 + i, mk_data(400 + i), 1'b0);
            drive(1'b1, 32'(400 + i), mk_data(400 + i), 1'b0);
        end
        drive(1'b1, 32'd500, mk_data(500), 1'b1);
        expect_marker();
        check("pre_rst_pending", 128'(dut.r_eof_pending), 128'(1));
        check("pre_rst_level", 128'(vif.fifo_level), 128'(16));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_wvalid", 128'(vif.mem_wvalid), 128'(0));
        check("mid_rst_waddr", 128'(vif.mem_waddr), 128'(0));
        check("mid_rst_wdata", 128'(vif.mem_wdata), 128'(0));
        check("mid_rst_fc", 128'(vif.frame_complete), 128'(0));
        check("mid_rst_buf_sel", 128'(vif.buf_sel), 128'(0));
        check("mid_rst_level", 128'(vif.fifo_level), 128'(0));
        check("mid_rst_overflow", 128'(vif.overflow_count), 128'(0));
        check("mid_rst_range_err", 128'(vif.range_err_count), 128'(0));
        check("mid_rst_pending", 128'(dut.r_eof_pending), 128'(0));
        sb_q.delete();
        m_buf = 1'b0;
        fc_before = fc_total;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vif.mem_wready = 1'b1;
        idle(30);
        check("post_rst_fc_total", 128'(fc_total), 128'(fc_before));
        check("post_rst_level", 128'(vif.fifo_level), 128'(0));
        check("post_rst_wvalid", 128'(vif.mem_wvalid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
